// File: rtl/pmt_ram_pkg.sv
// Shared types and helpers for the PMT event capture RAM controller.
// Holds the run-state encoding, default field widths and RAM word packing.
package pmt_ram_pkg;

    localparam int DATASIZE  = 16;
    localparam int COUNTSIZE = 32;
    localparam int RAMW      = DATASIZE + COUNTSIZE;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    function automatic logic [RAMW-1:0] pack_word(
        input logic [DATASIZE-1:0]  diff,
        input logic [COUNTSIZE-1:0] cnt
    );
        return {cnt, diff};
    endfunction

    function automatic logic [DATASIZE-1:0] word_diff(input logic [RAMW-1:0] w);
        return w[DATASIZE-1:0];
    endfunction

    function automatic logic [COUNTSIZE-1:0] word_count(input logic [RAMW-1:0] w);
        return w[RAMW-1:DATASIZE];
    endfunction

endpackage

// File: rtl/g_rd_skid2.sv
// Two-entry valid/ready output buffer fed by a 1-cycle-latency RAM read.
// Ports: in_valid/in_data push, out_valid/out_ready/out_data pop, free = empty slots.
module g_rd_skid2 #(
    parameter int W = 49
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   free
);

    logic [W-1:0] buf0_q, buf0_d;
    logic [W-1:0] buf1_q, buf1_d;
    logic         head_q, head_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         tail;
    logic         pop;

    always_comb begin
        pop    = (cnt_q != 2'd0) && out_ready;
        // Slot after the head when one entry is held, else the head slot.
        tail   = head_q ^ cnt_q[0];
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (in_valid) begin
            if (tail) buf1_d = in_data;
            else      buf0_d = in_data;
        end
        head_d = head_q ^ pop;
        cnt_d  = cnt_q + {1'b0, in_valid} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf0_q <= '0;
            buf1_q <= '0;
            head_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
            head_q <= head_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = !out_valid ? '0 : (head_q ? buf1_q : buf0_q);
    assign free      = 2'd2 - cnt_q;

endmodule

// File: rtl/g_ram_capture_ctrl.sv
// Captures g_clk-domain PMT events into an external dual-port RAM and drains it.
// Ports: g_valid/g_diff/g_diff_count events, g_arm/g_stop/g_rd_start control,
// ram_* RAM write/read side, o_* valid/ready readout, g_state/g_nwords/g_drop_cnt status.
import pmt_ram_pkg::*;

module g_ram_capture_ctrl #(
    parameter int DATASIZE  = 16,
    parameter int COUNTSIZE = 32,
    parameter int ADDRW     = 10,
    parameter int DROPW     = 16
) (
    input  logic                          g_clk,
    input  logic                          g_rst_n,
    input  logic                          g_valid,
    input  logic [DATASIZE-1:0]           g_diff,
    input  logic [COUNTSIZE-1:0]          g_diff_count,
    input  logic                          g_arm,
    input  logic                          g_stop,
    input  logic                          g_rd_start,
    output logic                          ram_we,
    output logic [ADDRW-1:0]              ram_waddr,
    output logic [DATASIZE+COUNTSIZE-1:0] ram_wdata,
    output logic                          ram_re,
    output logic [ADDRW-1:0]              ram_raddr,
    input  logic [DATASIZE+COUNTSIZE-1:0] ram_rdata,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic [DATASIZE+COUNTSIZE-1:0] o_data,
    output logic                          o_last,
    output logic [1:0]                    g_state,
    output logic [ADDRW:0]                g_nwords,
    output logic [DROPW-1:0]              g_drop_cnt
);

    localparam int W  = DATASIZE + COUNTSIZE;
    localparam int NW = ADDRW + 1;
    localparam logic [ADDRW-1:0] ONE_A = {{(ADDRW-1){1'b0}}, 1'b1};
    localparam logic [NW-1:0]    ONE_N = {{ADDRW{1'b0}}, 1'b1};
    localparam logic [DROPW-1:0] ONE_D = {{(DROPW-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [NW-1:0]     nwords_q, nwords_d;
    logic [NW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DROPW-1:0]  drop_q, drop_d;
    logic              we_q, we_d;
    logic [ADDRW-1:0]  waddr_q, waddr_d;
    logic [W-1:0]      wdata_q, wdata_d;
    logic              rvalid_q, rlast_q;

    logic              drop_ev;
    logic              pop;
    logic              rd_issue;
    logic              last_rd;
    logic [2:0]        room;
    logic [1:0]        sk_free;
    logic [W:0]        sk_out;

    always_comb begin
        pop      = o_valid && o_ready;
        // Room exists if the buffer can absorb the word already returning
        // from RAM plus this new read, net of the word leaving this cycle.
        room     = {1'b0, sk_free} + {2'b0, pop};
        rd_issue = (state_q == ST_DRAIN) && (rd_ptr_q < nwords_q)
                   && (room > {2'b0, rvalid_q});
        last_rd  = (rd_ptr_q == nwords_q - ONE_N);
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        nwords_d = nwords_q;
        rd_ptr_d = rd_ptr_q;
        drop_d   = drop_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        drop_ev  = g_valid;
        unique case (state_q)
            ST_IDLE: begin
                if (g_arm) begin
                    state_d  = ST_CAPTURE;
                    wr_ptr_d = '0;
                    nwords_d = '0;
                    drop_d   = '0;
                end
            end
            ST_CAPTURE: begin
                if (g_arm) begin
                    wr_ptr_d = '0;
                    nwords_d = '0;
                end else begin
                    drop_ev = 1'b0;
                    if (g_valid) begin
                        we_d     = 1'b1;
                        waddr_d  = wr_ptr_q;
                        wdata_d  = {g_diff_count, g_diff};
                        wr_ptr_d = wr_ptr_q + ONE_A;
                        nwords_d = nwords_q + ONE_N;
                        if (&wr_ptr_q) state_d = ST_DONE;
                    end
                    if (g_stop) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (g_arm) begin
                    state_d  = ST_CAPTURE;
                    wr_ptr_d = '0;
                    nwords_d = '0;
                end else if (g_rd_start) begin
                    rd_ptr_d = '0;
                    state_d  = (nwords_q == '0) ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (rd_issue) rd_ptr_d = rd_ptr_q + ONE_N;
                if (pop && o_last) state_d = ST_IDLE;
            end
        endcase
        if (drop_ev && !(&drop_d)) drop_d = drop_d + ONE_D;
    end

    always_ff @(posedge g_clk or negedge g_rst_n) begin
        if (!g_rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            nwords_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            nwords_q <= nwords_d;
            rd_ptr_q <= rd_ptr_d;
            drop_q   <= drop_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rd_issue;
            rlast_q  <= rd_issue && last_rd;
        end
    end

    g_rd_skid2 #(
        .W (W + 1)
    ) u_skid (
        .clk       (g_clk),
        .rst_n     (g_rst_n),
        .in_valid  (rvalid_q),
        .in_data   ({rlast_q, ram_rdata}),
        .out_valid (o_valid),
        .out_ready (o_ready),
        .out_data  (sk_out),
        .free      (sk_free)
    );

    assign o_last     = sk_out[W];
    assign o_data     = sk_out[W-1:0];
    assign ram_we     = we_q;
    assign ram_waddr  = waddr_q;
    assign ram_wdata  = wdata_q;
    assign ram_re     = rd_issue;
    assign ram_raddr  = rd_ptr_q[ADDRW-1:0];
    assign g_state    = state_q;
    assign g_nwords   = nwords_q;
    assign g_drop_cnt = drop_q;

endmodule
